pe_rr_arbiter: RTL

- Parametrised, registered round-robin successor to the 4-input fixed-priority PE cell, for the same request/grant arbitration tree.
- Arbitrates N request lines and locks the grant on the winner until it drops its request.
- Request_OUT propagates up the tree and Grant_IN gates arbitration from the parent, so instances cascade like the existing PE.
- Replaces fixed priority (line 0 always wins) with a rotating pointer to remove starvation.

---
 rtl/pe_rr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pe_rr_arbiter.sv
// Registered round-robin arbiter cell: N requests in, one-hot locked grant out, cascadable via Request_OUT/Grant_IN.
// Latency: request to grant 1 cycle; release forces one idle bubble before the next grant.
// Backpressure: Grant_IN low blocks new grants and preempts the owner; optional PE_HOLD_LIMIT_EN caps hold at HOLD_MAX cycles.
module pe_rr_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 16,
    localparam int IDX_W   = $clog2(N)
) (
    input  logic             Clock_IN,
    input  logic             Reset_IN,
    input  logic             Grant_IN,
    input  logic [N-1:0]     Request_IN,
    output logic             Request_OUT,
    output logic [N-1:0]     Grant_OUT,
    output logic [IDX_W-1:0] Grant_Index,
    output logic             Grant_Valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             vld_q, vld_d;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] ptr_inc;
    logic             hold_expired;

    if (N < 2 || N > 32 || HOLD_MAX < 1) begin : g_bad_param
        $error("pe_rr_arbiter: illegal parameter value");
    end

`ifdef PE_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    logic [CNT_W-1:0] hold_q, hold_d;
    assign hold_expired = (hold_q == CNT_W'(HOLD_MAX - 1));
`else
    assign hold_expired = 1'b0;
`endif

    assign Request_OUT = |Request_IN;
    assign Grant_OUT   = gnt_q;
    assign Grant_Index = idx_q;
    assign Grant_Valid = vld_q;

    // Explicit wrap so non-power-of-2 N returns to line 0.
    assign ptr_inc = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);

    // First asserted request at or above the pointer, wrapping around.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!win_found && Request_IN[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
`ifdef PE_HOLD_LIMIT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                idx_d = '0;
                vld_d = 1'b0;
                if (Grant_IN && win_found) begin
                    state_d = GRANT;
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    idx_d   = win_idx;
                    vld_d   = 1'b1;
`ifdef PE_HOLD_LIMIT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
`ifdef PE_HOLD_LIMIT_EN
                hold_d = hold_q + CNT_W'(1);
`endif
                // Release outranks preemption so a dropped owner still advances the pointer.
                if (!Request_IN[idx_q] || hold_expired) begin
                    state_d = IDLE;
                    ptr_d   = ptr_inc;
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                end else if (!Grant_IN) begin
                    state_d = IDLE;
                    ptr_d   = idx_q;
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock_IN or posedge Reset_IN) begin
        if (Reset_IN) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
`ifdef PE_HOLD_LIMIT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
`ifdef PE_HOLD_LIMIT_EN
            hold_q  <= hold_d;
`endif
        end
    end

endmodule
